// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED status controller.
//
// Drives CHANNELS LEDs from one system clock. Each channel shows one of
// five patterns: off, on, slow blink, fast blink or an N-flash code. A
// shared prescaler makes the pattern tick. A shared 0..999 phase counter
// times both blink modes. Each channel has its own small FSM for the flash
// code. While `run` is low (normally PLL not yet locked), every counter and
// FSM is held cleared and all LEDs stay dark.
//
// Parameters:
//   CHANNELS    number of LED channels (1..16)
//   CLK_HZ      frequency of `clock` in Hz
//   TICK_HZ     pattern tick rate; all pattern durations are in ticks
//   ACTIVE_LOW  1: a lit LED drives 0; 0: a lit LED drives 1
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   run      in   global enable; low clears all state and darkens the LEDs
//   mode     in   3 bits per channel: 0 off, 1 on, 2 slow, 3 fast,
//                 4 flash, 5..7 off
//   flash_n  in   4 bits per channel: flash count used in mode 4
//   led      out  LED pins (registered, polarity from ACTIVE_LOW)
//   tick     out  registered one-cycle strobe at TICK_HZ
module led_status_ctrl #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic [3*CHANNELS-1:0]   mode,
  input  logic [4*CHANNELS-1:0]   flash_n,
  output logic [CHANNELS-1:0]     led,
  output logic                    tick
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PreW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_prescale_chk
    $error("led_status_ctrl: CLK_HZ / TICK_HZ must be at least 2");
  end
  if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_channels_chk
    $error("led_status_ctrl: CHANNELS must be in 1..16");
  end

  localparam logic LitLvl  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic DarkLvl = ~LitLvl;

  localparam logic [2:0] ModeOn    = 3'd1;
  localparam logic [2:0] ModeSlow  = 3'd2;
  localparam logic [2:0] ModeFast  = 3'd3;
  localparam logic [2:0] ModeFlash = 3'd4;

  // Last tick count of each timed interval (durations 150, 150, 1000).
  localparam logic [9:0] OnLast    = 10'd149;
  localparam logic [9:0] OffLast   = 10'd149;
  localparam logic [9:0] GapLast   = 10'd999;
  localparam logic [9:0] PhaseLast = 10'd999;
  localparam logic [9:0] SlowHalf  = 10'd500;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff,
    StGap
  } flash_st_e;

  // Shared timing
  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;
  logic [9:0]      phase_q, phase_d;

  // Per-channel state
  logic [3*CHANNELS-1:0] mode_q;
  flash_st_e             st_q   [CHANNELS];
  flash_st_e             st_d   [CHANNELS];
  logic [9:0]            dur_q  [CHANNELS];
  logic [9:0]            dur_d  [CHANNELS];
  logic [3:0]            fcnt_q [CHANNELS];
  logic [3:0]            fcnt_d [CHANNELS];
  logic [CHANNELS-1:0]   steady_q, steady_d;
  logic [CHANNELS-1:0]   led_q, led_d;

  // Unpacked per-channel views of the packed buses
  logic [2:0] mode_new [CHANNELS];
  logic [2:0] mode_cur [CHANNELS];
  logic [3:0] fn       [CHANNELS];

  // True for phase mod 250 < 125; written as ranges to avoid a divider.
  function automatic logic fast_lit(input logic [9:0] p);
    return (p < 10'd125) ||
           ((p >= 10'd250) && (p < 10'd375)) ||
           ((p >= 10'd500) && (p < 10'd625)) ||
           ((p >= 10'd750) && (p < 10'd875));
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_new[i] = mode[3*i +: 3];
      mode_cur[i] = mode_q[3*i +: 3];
      fn[i]       = flash_n[4*i +: 4];
    end
  end

  // Prescaler, tick and phase. tick_q is high exactly while pre_q holds
  // PreMax, so the phase and the flash FSMs both advance on the wrap edge.
  always_comb begin
    pre_d   = pre_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    if (!run) begin
      pre_d   = '0;
      phase_d = '0;
    end else begin
      pre_d  = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
      tick_d = (pre_d == PreMax);
      if (tick_q) begin
        phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 10'd1;
      end
    end
  end

  // Flash FSMs. Both run low and a mode change force IDLE. A mode change
  // wins over a tick in the same cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      st_d[i]   = st_q[i];
      dur_d[i]  = dur_q[i];
      fcnt_d[i] = fcnt_q[i];
      if (!run || (mode_new[i] != mode_cur[i])) begin
        st_d[i]   = StIdle;
        dur_d[i]  = '0;
        fcnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          StIdle: begin
            if ((mode_cur[i] == ModeFlash) && (fn[i] != 4'd0)) begin
              st_d[i]   = StOn;
              fcnt_d[i] = fn[i];
              dur_d[i]  = '0;
            end
          end
          StOn: begin
            if (tick_q) begin
              if (dur_q[i] == OnLast) begin
                st_d[i]  = StOff;
                dur_d[i] = '0;
              end else begin
                dur_d[i] = dur_q[i] + 10'd1;
              end
            end
          end
          StOff: begin
            if (tick_q) begin
              if (dur_q[i] == OffLast) begin
                dur_d[i] = '0;
                // Decremented count nonzero <=> count was above 1.
                if (fcnt_q[i] > 4'd1) begin
                  st_d[i]   = StOn;
                  fcnt_d[i] = fcnt_q[i] - 4'd1;
                end else begin
                  st_d[i]   = StGap;
                  fcnt_d[i] = '0;
                end
              end else begin
                dur_d[i] = dur_q[i] + 10'd1;
              end
            end
          end
          StGap: begin
            if (tick_q) begin
              if (dur_q[i] == GapLast) begin
                dur_d[i] = '0;
                // A zero count reloaded here parks the channel dark.
                if (fn[i] != 4'd0) begin
                  st_d[i]   = StOn;
                  fcnt_d[i] = fn[i];
                end else begin
                  st_d[i]   = StIdle;
                  fcnt_d[i] = '0;
                end
              end else begin
                dur_d[i] = dur_q[i] + 10'd1;
              end
            end
          end
          default: begin
            st_d[i]   = StIdle;
            dur_d[i]  = '0;
            fcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Lit value and LED drive. The non-flash modes go through steady_q, so
  // every mode reaches the pin two edges after mode_q changes: one edge for
  // the lit value and one for the LED register.
  always_comb begin
    steady_d = '0;
    led_d    = {CHANNELS{DarkLvl}};
    for (int i = 0; i < CHANNELS; i++) begin
      steady_d[i] = run &&
                    ((mode_cur[i] == ModeOn) ||
                     ((mode_cur[i] == ModeSlow) && (phase_q < SlowHalf)) ||
                     ((mode_cur[i] == ModeFast) && fast_lit(phase_q)));
      if (run && ((mode_cur[i] == ModeFlash) ? (st_q[i] == StOn) : steady_q[i])) begin
        led_d[i] = LitLvl;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      tick_q   <= 1'b0;
      phase_q  <= '0;
      mode_q   <= '0;
      steady_q <= '0;
      led_q    <= {CHANNELS{DarkLvl}};
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]   <= StIdle;
        dur_q[i]  <= '0;
        fcnt_q[i] <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      mode_q   <= mode;
      steady_q <= steady_d;
      led_q    <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]   <= st_d[i];
        dur_q[i]  <= dur_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule
